// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core pipeline: control-vector bit positions
// and load funct3 encodings used by the EX/MEM/WB registers and load alignment.
package core_pkg;

  localparam int WE_REG    = 0;
  localparam int WE_LOAD   = 1;
  localparam int WE_BE_LSB = 2;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_e;

endpackage

// File: rtl/ex_mem_wb_pipe_load_align.sv
// Combinational load alignment: picks the byte/halfword lane addressed by the
// load and sign- or zero-extends it; unlisted funct3 values behave as LW.
module load_align
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] byte_shifted;
  logic [XLEN-1:0] half_shifted;
  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;

  // Halfword lane selection ignores addr[0]; misaligned halfwords are not split.
  always_comb begin
    byte_shifted = rdata >> {addr, 3'b000};
    half_shifted = rdata >> {addr[1], 4'b0000};
    byte_lane    = byte_shifted[7:0];
    half_lane    = half_shifted[15:0];
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F3_LH:   result = {{(XLEN-16){half_lane[15]}}, half_lane};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_lane};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_lane};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers: drive data-memory requests from MEM,
// align load data in WB, and count retired instructions.
module ex_mem_wb_pipe
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic [7:0]       ex_we,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_alu_result,
  input  logic [XLEN-1:0]  ex_store_data,
  input  logic             stall_mem,
  input  logic             flush_ex,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic [4:0]       mem_rd,
  output logic [7:0]       mem_we,
  output logic [XLEN-1:0]  mem_alu_result,
  output logic [XLEN-1:0]  dmem_wdata,
  output logic [3:0]       dmem_be,
  output logic             dmem_re,
  output logic [4:0]       writeback_rd,
  output logic             writeback,
  output logic [XLEN-1:0]  writeback_data,
  output logic [CNT_W-1:0] instret
);

  logic            mem_valid;
  logic [2:0]      mem_funct3;
  logic [XLEN-1:0] mem_store_data;

  logic            wb_valid;
  logic            wb_load;
  logic [2:0]      wb_funct3;
  logic [XLEN-1:0] wb_alu_result;
  logic [XLEN-1:0] wb_load_data;

  logic            ex_reg_we;
  logic            mem_issue;
  logic [7:0]      be_shifted;

  // Register writes to x0 are dropped here so forwarding never matches rd==0.
  assign ex_reg_we = ex_we[WE_REG] & (|ex_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid      <= 1'b0;
      mem_rd         <= '0;
      mem_we         <= '0;
      mem_funct3     <= '0;
      mem_alu_result <= '0;
      mem_store_data <= '0;
    end else if (!stall_mem) begin
      if (flush_ex || !ex_valid) begin
        mem_valid      <= 1'b0;
        mem_rd         <= '0;
        mem_we         <= '0;
        mem_funct3     <= '0;
        mem_alu_result <= '0;
        mem_store_data <= '0;
      end else begin
        mem_valid      <= 1'b1;
        mem_rd         <= ex_rd;
        mem_we         <= {ex_we[7:WE_LOAD], ex_reg_we};
        mem_funct3     <= ex_funct3;
        mem_alu_result <= ex_alu_result;
        mem_store_data <= ex_store_data;
      end
    end
  end

  // A stalled MEM stage hands a bubble to WB while it keeps its own contents.
  always_ff @(posedge clk) begin
    if (reset || stall_mem) begin
      wb_valid      <= 1'b0;
      writeback_rd  <= '0;
      writeback     <= 1'b0;
      wb_load       <= 1'b0;
      wb_funct3     <= '0;
      wb_alu_result <= '0;
    end else begin
      wb_valid      <= mem_valid;
      writeback_rd  <= mem_rd;
      writeback     <= mem_valid & mem_we[WE_REG] & (|mem_rd);
      wb_load       <= mem_valid & mem_we[WE_LOAD];
      wb_funct3     <= mem_funct3;
      wb_alu_result <= mem_alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instret <= '0;
    end else if (wb_valid) begin
      instret <= instret + CNT_W'(1);
    end
  end

  assign mem_issue  = mem_valid & ~stall_mem;
  assign dmem_re    = mem_issue & mem_we[WE_LOAD];
  assign be_shifted = {4'b0000, mem_we[WE_BE_LSB +: 4]} << mem_alu_result[1:0];
  assign dmem_be    = mem_issue ? be_shifted[3:0] : 4'b0000;
  assign dmem_wdata = mem_store_data << {mem_alu_result[1:0], 3'b000};

  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .funct3(wb_funct3),
    .addr  (wb_alu_result[1:0]),
    .rdata (dmem_rdata),
    .result(wb_load_data)
  );

  assign writeback_data = wb_load ? wb_load_data : wb_alu_result;

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Self-checking bench for ex_mem_wb_pipe: directed scenarios followed by random
// traffic, compared against an instruction-level model of the two stages.
module tb_ex_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic [7:0]  ex_we;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic        stall_mem;
  logic        flush_ex;
  logic [31:0] dmem_rdata;
  logic [4:0]  mem_rd;
  logic [7:0]  mem_we;
  logic [31:0] mem_alu_result;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_re;
  logic [4:0]  writeback_rd;
  logic        writeback;
  logic [31:0] writeback_data;
  logic [63:0] instret;

  int tests  = 0;
  int failed = 0;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [7:0]  we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
  } slot_t;

  slot_t       m_mem = '0;
  slot_t       m_wb  = '0;
  logic [63:0] m_instret = '0;

  ex_mem_wb_pipe #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_we(ex_we),
    .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .stall_mem(stall_mem), .flush_ex(flush_ex), .dmem_rdata(dmem_rdata),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_alu_result(mem_alu_result),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_re(dmem_re),
    .writeback_rd(writeback_rd), .writeback(writeback),
    .writeback_data(writeback_data), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference load result from the architectural rules, using plain shifts and masks.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * a)) & 32'hFF;
    h = (d >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return d;
    endcase
  endfunction

  task automatic apply_stimulus(input bit v, input logic [4:0] rd, input logic [7:0] we,
                                input logic [2:0] f3, input logic [31:0] alu,
                                input logic [31:0] sd);
    ex_valid = v; ex_rd = rd; ex_we = we; ex_funct3 = f3;
    ex_alu_result = alu; ex_store_data = sd;
  endtask

  task automatic model_update();
    slot_t nxt_wb;
    if (reset) begin
      m_mem = '0; m_wb = '0; m_instret = '0;
    end else begin
      if (m_wb.valid) m_instret = m_instret + 64'd1;
      nxt_wb = stall_mem ? '0 : m_mem;
      if (!stall_mem)
        m_mem = (flush_ex || !ex_valid) ? '0
              : '{1'b1, ex_rd, ex_we, ex_funct3, ex_alu_result, ex_store_data};
      m_wb = nxt_wb;
    end
  endtask

  task automatic check_output(input bit regs);
    logic [7:0]  exp_we;
    logic [31:0] exp_be;
    if (regs) begin
      exp_we = m_mem.we;
      if (m_mem.rd == 5'd0) exp_we[0] = 1'b0;
      check("mem_rd", 64'(mem_rd), 64'(m_mem.rd));
      check("mem_we", 64'(mem_we), 64'(exp_we));
      if (m_mem.valid) check("mem_alu_result", 64'(mem_alu_result), 64'(m_mem.addr));
      check("writeback", 64'(writeback), 64'(m_wb.valid && m_wb.we[0] && m_wb.rd != 5'd0));
      if (m_wb.valid) check("writeback_rd", 64'(writeback_rd), 64'(m_wb.rd));
      check("instret", instret, m_instret);
    end else begin
      exp_be = (m_mem.valid && !stall_mem)
             ? ((32'(m_mem.we[5:2]) << m_mem.addr[1:0]) & 32'hF) : 32'd0;
      check("dmem_be", 64'(dmem_be), 64'(exp_be));
      check("dmem_re", 64'(dmem_re), 64'(m_mem.valid && m_mem.we[1] && !stall_mem));
      if (m_mem.valid)
        check("dmem_wdata", 64'(dmem_wdata), 64'(32'(m_mem.sdata << (8 * m_mem.addr[1:0]))));
      if (m_wb.valid)
        check("writeback_data", 64'(writeback_data),
              64'(m_wb.we[1] ? ref_load(m_wb.f3, m_wb.addr[1:0], dmem_rdata) : m_wb.addr));
    end
  endtask

  task automatic step(input bit comb);
    #1;
    if (comb) check_output(1'b0);
    @(posedge clk);
    model_update();
    #1;
    check_output(1'b1);
  endtask

  initial begin
    logic [7:0]  rwe;
    logic [2:0]  rf3;
    logic [3:0]  rmask;
    logic [2:0]  f3_pick [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
    logic [3:0]  mask_pick [3] = '{4'h1, 4'h3, 4'hF};
    reset = 1'b1; stall_mem = 1'b0; flush_ex = 1'b0; dmem_rdata = '0;
    apply_stimulus(1'b1, 5'd5, 8'h01, 3'b000, 32'h1234, 32'h0);

    step(1'b0);
    check("reset_mem_we", 64'(mem_we), 64'h0);

    reset = 1'b0;
    step(1'b1);
    check("add_mem_rd", 64'(mem_rd), 64'd5);
    check("add_mem_we0", 64'(mem_we[0]), 64'd1);

    apply_stimulus(1'b1, 5'd0, 8'h01, 3'b000, 32'h55, 32'h0);
    step(1'b1);
    check("add_writeback", 64'(writeback), 64'd1);
    check("x0_mem_we0", 64'(mem_we[0]), 64'd0);
    #1 check("add_wb_data", 64'(writeback_data), 64'h1234);

    apply_stimulus(1'b1, 5'd7, 8'h03, 3'b000, 32'h103, 32'h0);
    step(1'b1);
    check("x0_writeback", 64'(writeback), 64'd0);
    check("x0_instret", instret, 64'd1);

    apply_stimulus(1'b1, 5'd8, 8'h03, 3'b101, 32'h102, 32'h0);
    step(1'b1);
    dmem_rdata = 32'h80FF_FF7F;
    #1 check("lb_data", 64'(writeback_data), 64'hFFFF_FF80);

    apply_stimulus(1'b0, 5'd0, 8'h00, 3'b000, 32'h0, 32'h0);
    step(1'b1);
    #1 check("lhu_data", 64'(writeback_data), 64'h0000_80FF);

    apply_stimulus(1'b1, 5'd9, 8'h03, 3'b010, 32'h200, 32'h0);
    step(1'b1);
    apply_stimulus(1'b0, 5'd0, 8'h00, 3'b000, 32'h0, 32'h0);
    stall_mem = 1'b1;
    #1 check("stall_dmem_re", 64'(dmem_re), 64'd0);
    step(1'b1);
    check("stall1_mem_rd", 64'(mem_rd), 64'd9);
    check("stall1_wb", 64'(writeback), 64'd0);
    step(1'b1);
    check("stall2_mem_rd", 64'(mem_rd), 64'd9);
    check("stall2_wb", 64'(writeback), 64'd0);
    stall_mem = 1'b0;
    #1 check("unstall_dmem_re", 64'(dmem_re), 64'd1);
    step(1'b1);
    check("lw_writeback", 64'(writeback), 64'd1);
    check("lw_wb_rd", 64'(writeback_rd), 64'd9);
    step(1'b1);
    check("lw_once", 64'(writeback), 64'd0);

    apply_stimulus(1'b1, 5'd0, 8'h3C, 3'b010, 32'h300, 32'hDEAD_BEEF);
    flush_ex = 1'b1;
    step(1'b1);
    flush_ex = 1'b0;
    apply_stimulus(1'b0, 5'd0, 8'h00, 3'b000, 32'h0, 32'h0);
    check("flush_mem_we", 64'(mem_we), 64'h0);
    #1 check("flush_dmem_be", 64'(dmem_be), 64'h0);
    step(1'b1);

    apply_stimulus(1'b1, 5'd0, 8'h04, 3'b000, 32'h301, 32'h0000_00AB);
    step(1'b1);
    apply_stimulus(1'b1, 5'd3, 8'h01, 3'b000, 32'h77, 32'h0);
    flush_ex = 1'b1; stall_mem = 1'b1;
    step(1'b1);
    check("hold_mem_we", 64'(mem_we), 64'h04);
    check("hold_mem_addr", 64'(mem_alu_result), 64'h301);
    flush_ex = 1'b0; stall_mem = 1'b0;
    apply_stimulus(1'b0, 5'd0, 8'h00, 3'b000, 32'h0, 32'h0);
    #1 check("sb_dmem_be", 64'(dmem_be), 64'h2);
    step(1'b1);

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: begin rwe = 8'h01; rf3 = 3'b000; end
        1: begin rwe = 8'h03; rf3 = f3_pick[$urandom_range(0, 5)]; end
        2: begin rmask = mask_pick[$urandom_range(0, 2)]; rwe = {2'b00, rmask, 2'b00}; rf3 = 3'b010; end
        default: begin rwe = 8'h00; rf3 = 3'b000; end
      endcase
      apply_stimulus($urandom_range(0, 9) < 8,
                     ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
                     rwe, rf3, $urandom, $urandom);
      stall_mem  = $urandom_range(0, 99) < 15;
      flush_ex   = $urandom_range(0, 99) < 10;
      reset      = $urandom_range(0, 199) == 0;
      dmem_rdata = $urandom;
      step(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
